alu_result_display: RTL and testbench

- Output stage placed directly after the 6-bit ALU result multiplexer.
- Captures the selected 6-bit result and the 3-bit opcode that selected it.
- Drives the Basys 3 4-digit common-anode seven-segment display, time-multiplexed.
- Shows the opcode, a separator and the result in hex. The decimal point flashes briefly whenever the displayed value changes.

---
 rtl/alu_result_display.sv | 207 ++++++++++++++++++++
 tb/tb_alu_result_display.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_display.sv
// -----------------------------------------------------------------------------
// alu_result_display
//
// Output stage that sits after the 6-bit ALU result multiplexer. It captures
// the selected result together with the 3-bit opcode that selected it, and
// drives the Basys 3 four-digit common-anode seven-segment display,
// time-multiplexed, showing (left to right):
//
//   digit 3: opcode (0..7)   digit 2: dash   digit 1: result[5:4]   digit 0: result[3:0]
//
// The decimal point on digit 0 lights for FLASH_CYCLES cycles whenever a
// capture changes the displayed {opcode, result}.
//
// Parameters:
//   REFRESH_DIV   clock cycles each digit stays lit (>= 2)
//   FLASH_CYCLES  cycles the change-indicator dp stays lit (>= 1)
//
// Ports:
//   clk           system clock (100 MHz)
//   reset_n       asynchronous active-low reset
//   result        ALU result from the multiplexer output
//   opcode        opcode currently driving the multiplexer select
//   result_valid  capture strobe; result/opcode sampled while high
//   freeze        when high, captures are ignored
//   an            digit anodes, active-low, one-hot while scanning
//   seg           segments {g,f,e,d,c,b,a}, active-low
//   dp            decimal point, active-low
//   shown_result  currently captured result
// -----------------------------------------------------------------------------
module alu_result_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int FLASH_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] result,
    input  logic [2:0] opcode,
    input  logic       result_valid,
    input  logic       freeze,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] shown_result
);

    localparam int REF_W   = $clog2(REFRESH_DIV);
    localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

    localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_DIV - 1);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Scan position; the encoding doubles as the rotation order.
    typedef enum logic [1:0] {
        DIG_RES_LO = 2'd0,
        DIG_RES_HI = 2'd1,
        DIG_SEP    = 2'd2,
        DIG_OPCODE = 2'd3
    } digit_e;

    // Active-low hex font, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Captured data
    logic [5:0]         res_q, res_d;
    logic [2:0]         op_q, op_d;
    // Change indicator
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    // Scan timing
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    digit_e             idx_q, idx_d;
    // Registered display drive
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic capture;
    logic data_changed;

    // -------------------------------------------------------------------------
    // Capture and change flash
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        res_d        = res_q;
        op_d         = op_q;
        flash_cnt_d  = flash_cnt_q;
        capture      = result_valid & ~freeze;
        data_changed = ({opcode, result} != {op_q, res_q});

        if (capture) begin
            res_d = result;
            op_d  = opcode;
        end

        // Only a capture that alters what is shown restarts the flash;
        // re-capturing identical data lets a running flash expire normally.
        // freeze gates capture only, so the countdown keeps running.
        if (capture && data_changed) begin
            flash_cnt_d = FLASH_LOAD;
        end else if (flash_cnt_q != '0) begin
            flash_cnt_d = flash_cnt_q - FLASH_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Digit scan
    // -------------------------------------------------------------------------
    always_comb begin
        ref_cnt_d = ref_cnt_q + REF_W'(1);
        idx_d     = idx_q;
        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            idx_d     = digit_e'(idx_q + 2'd1);
        end
    end

    // -------------------------------------------------------------------------
    // Display drive, decoded from the current index and current captured data.
    // Registering it keeps the pins glitch-free; the cost is one cycle of lag.
    // -------------------------------------------------------------------------
    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        case (idx_q)
            DIG_RES_LO: begin
                an_d  = 4'b1110;
                seg_d = hex_to_seg(res_q[3:0]);
                dp_d  = (flash_cnt_q == '0);
            end
            DIG_RES_HI: begin
                an_d  = 4'b1101;
                seg_d = hex_to_seg({2'b00, res_q[5:4]});
            end
            DIG_SEP: begin
                an_d  = 4'b1011;
                seg_d = SEG_DASH;
            end
            DIG_OPCODE: begin
                an_d  = 4'b0111;
                seg_d = hex_to_seg({1'b0, op_q});
            end
            default: begin
                an_d  = 4'b1111;
                seg_d = SEG_OFF;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments so every flop samples the pre-edge values
    // of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q       <= '0;
            op_q        <= '0;
            flash_cnt_q <= '0;
            ref_cnt_q   <= '0;
            idx_q       <= DIG_RES_LO;
            an_q        <= 4'b1111;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            res_q       <= res_d;
            op_q        <= op_d;
            flash_cnt_q <= flash_cnt_d;
            ref_cnt_q   <= ref_cnt_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an           = an_q;
    assign seg          = seg_q;
    assign dp           = dp_q;
    assign shown_result = res_q;

endmodule

// File: tb/tb_alu_result_display.sv
// -----------------------------------------------------------------------------
// tb_alu_result_display
//
// Directed bench for alu_result_display with REFRESH_DIV=4, FLASH_CYCLES=10.
// edge_n counts rising clock edges since the last reset release; with a
// 4-cycle refresh the digit lit after edge k is ((k-1)/4) mod 4, so idx0 is
// lit after edges 1-4, 17-20, 33-36, 49-52, 65-68, 81-84, 97-100.
// A capture on edge E lights dp on idx0 for edges E+1..E+10.
// -----------------------------------------------------------------------------
module tb_alu_result_display;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_F    = 7'b0001110;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] result;
    logic [2:0] opcode;
    logic       result_valid;
    logic       freeze;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] shown_result;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;
    bit scan_on     = 1'b0;

    logic [3:0] an_rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    alu_result_display #(
        .REFRESH_DIV (4),
        .FLASH_CYCLES(10)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .result      (result),
        .opcode      (opcode),
        .result_valid(result_valid),
        .freeze      (freeze),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .shown_result(shown_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Advance to edge n, sampling 1 time unit after each rising edge.
    task automatic step_to(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (scan_on) check("an_onehot", 32'($countones(~an)), 32'd1);
        end
    endtask

    task automatic check_digit(input string tag, input logic [3:0] an_e,
                               input logic [6:0] seg_e, input logic dp_e);
        check({tag, "_an"},  32'(an),  32'(an_e));
        check({tag, "_seg"}, 32'(seg), 32'(seg_e));
        check({tag, "_dp"},  32'(dp),  32'(dp_e));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_digit(tag, 4'b1111, SEG_OFF, 1'b1);
        check({tag, "_shown"}, 32'(shown_result), 32'h0);
    endtask

    initial begin
        reset_n      = 1'b1;
        result       = '0;
        opcode       = '0;
        result_valid = 1'b0;
        freeze       = 1'b0;

        // ---- 1. reset and scan rotation ----
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("rst_hold");
        reset_n = 1'b1;
        edge_n  = 0;
        scan_on = 1'b1;
        step_to(1);
        check_digit("first_edge", 4'b1110, SEG_0, 1'b1);
        check("first_shown", 32'(shown_result), 32'h0);
        for (int k = 2; k <= 17; k++) begin
            step_to(k);
            check("rotate_an", 32'(an), 32'(an_rot[((k - 1) / 4) % 4]));
        end
        step_to(9);

        // ---- 2. capture 2F / op 5 on edge 24 ----
        step_to(23);
        check("pre_capture", 32'(shown_result), 32'h0);
        result = 6'h2F; opcode = 3'd5; result_valid = 1'b1;
        step_to(24);
        result_valid = 1'b0;
        check("capture_2f", 32'(shown_result), 32'h2F);
        step_to(25);
        check_digit("idx2_dash", 4'b1011, SEG_DASH, 1'b1);
        step_to(29);
        check_digit("idx3_op5", 4'b0111, SEG_5, 1'b1);
        // identical re-capture on edge 30 must not restart the flash
        result_valid = 1'b1;
        step_to(30);
        result_valid = 1'b0;
        step_to(33);
        check_digit("idx0_f_flash", 4'b1110, SEG_F, 1'b0);
        step_to(34);
        check("flash_last", 32'(dp), 32'd0);
        step_to(35);
        check("flash_end_noreload", 32'(dp), 32'd1);

        // ---- 3. reload: 2A on edge 36, 30 on edge 42 (6th flash cycle) ----
        result = 6'h2A; result_valid = 1'b1;
        step_to(36);
        result_valid = 1'b0;
        check("capture_2a", 32'(shown_result), 32'h2A);
        step_to(37);
        check_digit("idx1_2", 4'b1101, SEG_2, 1'b1);
        step_to(41);
        result = 6'h30; result_valid = 1'b1;
        step_to(42);
        result_valid = 1'b0;
        check("capture_30", 32'(shown_result), 32'h30);
        step_to(49);
        check_digit("reload_idx0", 4'b1110, SEG_0, 1'b0);
        step_to(52);
        check_digit("reload_last", 4'b1110, SEG_0, 1'b0);
        step_to(53);
        check_digit("idx1_3", 4'b1101, SEG_3, 1'b1);

        // ---- 4. freeze with valid held high, edges 54..73 ----
        freeze = 1'b1; result = 6'h3F; opcode = 3'd7; result_valid = 1'b1;
        step_to(65);
        check_digit("freeze_noflash", 4'b1110, SEG_0, 1'b1);
        check("freeze_hold_a", 32'(shown_result), 32'h30);
        step_to(73);
        check("freeze_hold_b", 32'(shown_result), 32'h30);
        freeze = 1'b0;
        step_to(74);
        result_valid = 1'b0;
        check("unfreeze_3f", 32'(shown_result), 32'h3F);

        // ---- 5. boundary values: 3F / op 7, then 00 / op 0 ----
        step_to(77);
        check_digit("max_idx3", 4'b0111, SEG_7, 1'b1);
        step_to(81);
        check_digit("max_idx0", 4'b1110, SEG_F, 1'b0);
        step_to(85);
        check_digit("max_idx1", 4'b1101, SEG_3, 1'b1);
        result = 6'h00; opcode = 3'd0; result_valid = 1'b1;
        step_to(86);
        result_valid = 1'b0;
        check("capture_00", 32'(shown_result), 32'h00);
        step_to(89);
        check_digit("min_idx2", 4'b1011, SEG_DASH, 1'b1);
        step_to(93);
        check_digit("min_idx3", 4'b0111, SEG_0, 1'b1);
        step_to(97);
        check_digit("min_idx0", 4'b1110, SEG_0, 1'b1);
        step_to(101);
        check_digit("min_idx1", 4'b1101, SEG_0, 1'b1);

        // ---- 6. reset during a flash while idx2 is lit ----
        result = 6'h11; opcode = 3'd1; result_valid = 1'b1;
        step_to(102);
        result_valid = 1'b0;
        step_to(105);
        check_digit("pre_reset_idx2", 4'b1011, SEG_DASH, 1'b1);
        step_to(106);
        scan_on = 1'b0;
        reset_n = 1'b0;
        #1 check_reset_outputs("mid_rst_async");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("mid_rst_hold");
        reset_n = 1'b1;
        edge_n  = 0;
        scan_on = 1'b1;
        step_to(1);
        check_digit("restart_idx0", 4'b1110, SEG_0, 1'b1);
        check("restart_shown", 32'(shown_result), 32'h0);
        step_to(4);
        check_digit("restart_noflash", 4'b1110, SEG_0, 1'b1);
        step_to(5);
        check("restart_idx1", 32'(an), 32'(4'b1101));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
